// File: rtl/dma_desc_scheduler_if.sv
// Descriptor bus between the scheduler and the single-channel DMA engine.
// The scheduler offers descriptors (valid/ready) and receives the engine's
// completion and error pulses on the same bundle.
interface dma_desc_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              desc_valid;
    logic              desc_ready;
    logic [ADDR_W-1:0] desc_src;
    logic [ADDR_W-1:0] desc_dst;
    logic [LEN_W-1:0]  desc_len;
    logic [CH_W-1:0]   desc_ch;
    logic              eng_done;
    logic              eng_error;

    modport master (
        output desc_valid, desc_src, desc_dst, desc_len, desc_ch,
        input  desc_ready, eng_done, eng_error
    );

    modport slave (
        input  desc_valid, desc_src, desc_dst, desc_len, desc_ch,
        output desc_ready, eng_done, eng_error
    );
endinterface

// File: rtl/dma_desc_scheduler.sv
// Multi-channel descriptor queue and round-robin scheduler feeding a single
// DMA engine. Each channel stages SRC/DST/LEN through CSR writes; a CFG write
// with start=1 enqueues the staged descriptor into that channel's FIFO.
// One descriptor is in flight at a time; completion raises done_irq for
// descriptors marked last, errors make the channel sticky-errored and flush it.
// Optional feature: define DMA_DESC_TIMEOUT_EN to build an engine watchdog
// that treats TIMEOUT_CYCLES cycles in BUSY as an engine error.
module dma_desc_scheduler #(
    parameter int NUM_CH         = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int ADDR_W         = 32,
    parameter int LEN_W          = 32,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    csr_we,
    input  logic [CH_W-1:0]         csr_ch,
    input  logic [1:0]              csr_sel,
    input  logic [31:0]             csr_wdata,
    dma_desc_scheduler_if.master    desc,
    output logic [NUM_CH*LVL_W-1:0] ch_level,
    output logic [NUM_CH-1:0]       ch_err,
    output logic [NUM_CH-1:0]       ch_ovf,
    output logic [NUM_CH-1:0]       done_irq,
    output logic                    err_irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // Reject parameter sets the FIFO pointer arithmetic and watchdog cannot support
    if (NUM_CH < 1 || NUM_CH > 8 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("dma_desc_scheduler: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t state, next_state;

    logic [ADDR_W-1:0] src_stage [NUM_CH];
    logic [ADDR_W-1:0] dst_stage [NUM_CH];
    logic [LEN_W-1:0]  len_stage [NUM_CH];

    logic [ADDR_W-1:0] fifo_src  [NUM_CH][FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_dst  [NUM_CH][FIFO_DEPTH];
    logic [LEN_W-1:0]  fifo_len  [NUM_CH][FIFO_DEPTH];
    logic              fifo_last [NUM_CH][FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr [NUM_CH];
    logic [PTR_W-1:0] rd_ptr [NUM_CH];
    logic [LVL_W-1:0] count  [NUM_CH];

    logic [NUM_CH-1:0] push_req, clr_req, pop_req, flush_req;
    logic [NUM_CH-1:0] push_ok, ovf_set, eligible;

    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] cur_ch;
    logic            busy_last;
    logic            grant_found;
    logic [CH_W-1:0] grant_ch;

    logic            pop_en;
    logic [CH_W-1:0] pop_ch;
    logic            done_set;
    logic [CH_W-1:0] done_ch;
    logic            err_set;
    logic            load_cur;
    logic            accept;
    logic            timeout;

    logic              cfg_write;
    logic [LEN_W-1:0]  grant_len;
    logic              grant_last;
    logic [ADDR_W-1:0] head_src;
    logic [ADDR_W-1:0] head_dst;
    logic [LEN_W-1:0]  head_len;
    logic              head_last;

    assign cfg_write  = csr_we && (csr_sel == 2'd3);
    assign grant_len  = fifo_len[grant_ch][rd_ptr[grant_ch]];
    assign grant_last = fifo_last[grant_ch][rd_ptr[grant_ch]];
    assign head_src   = fifo_src[cur_ch][rd_ptr[cur_ch]];
    assign head_dst   = fifo_dst[cur_ch][rd_ptr[cur_ch]];
    assign head_len   = fifo_len[cur_ch][rd_ptr[cur_ch]];
    assign head_last  = fifo_last[cur_ch][rd_ptr[cur_ch]];

    // Per-channel push/clear/pop/flush decode; clear_err is applied before the push check
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            push_req[i]  = cfg_write && csr_wdata[0] && (csr_ch == CH_W'(i));
            clr_req[i]   = cfg_write && csr_wdata[2] && (csr_ch == CH_W'(i));
            pop_req[i]   = pop_en && (pop_ch == CH_W'(i));
            flush_req[i] = err_set && (cur_ch == CH_W'(i));
            push_ok[i]   = push_req[i] && !(ch_err[i] && !clr_req[i]) && !flush_req[i] &&
                           ((count[i] != LVL_W'(FIFO_DEPTH)) || pop_req[i]);
            ovf_set[i]   = push_req[i] && !(ch_err[i] && !clr_req[i]) && !flush_req[i] &&
                           (count[i] == LVL_W'(FIFO_DEPTH)) && !pop_req[i];
            eligible[i]  = (count[i] != '0) && !ch_err[i];
        end
    end

    // Round-robin grant: first eligible channel at or after rr_ptr, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!grant_found && eligible[(int'(rr_ptr) + k) % NUM_CH]) begin
                grant_found = 1'b1;
                grant_ch    = CH_W'((int'(rr_ptr) + k) % NUM_CH);
            end
        end
    end

    // Staging registers hold the last written SRC/DST/LEN per channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                src_stage[i] <= '0;
                dst_stage[i] <= '0;
                len_stage[i] <= '0;
            end
        end else if (csr_we) begin
            case (csr_sel)
                2'd0:    src_stage[csr_ch] <= ADDR_W'(csr_wdata);
                2'd1:    dst_stage[csr_ch] <= ADDR_W'(csr_wdata);
                2'd2:    len_stage[csr_ch] <= LEN_W'(csr_wdata);
                default: ;
            endcase
        end
    end

    // FIFO storage writes at the tail of each accepting channel
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push_ok[i]) begin
                fifo_src[i][wr_ptr[i]]  <= src_stage[i];
                fifo_dst[i][wr_ptr[i]]  <= dst_stage[i];
                fifo_len[i][wr_ptr[i]]  <= len_stage[i];
                fifo_last[i][wr_ptr[i]] <= csr_wdata[1];
            end
        end
    end

    // FIFO pointers, occupancy and sticky error/overflow flags; a flush wins over push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            ch_err <= '0;
            ch_ovf <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr_req[i]) begin
                    ch_err[i] <= 1'b0;
                    ch_ovf[i] <= 1'b0;
                end
                if (ovf_set[i]) begin
                    ch_ovf[i] <= 1'b1;
                end
                if (flush_req[i]) begin
                    ch_err[i] <= 1'b1;
                    rd_ptr[i] <= wr_ptr[i];
                    count[i]  <= '0;
                end else begin
                    if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                    if (pop_req[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                    case ({push_ok[i], pop_req[i]})
                        2'b10:   count[i] <= count[i] + LVL_W'(1);
                        2'b01:   count[i] <= count[i] - LVL_W'(1);
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef DMA_DESC_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] to_cnt;

    // Watchdog counts cycles spent in BUSY and restarts from zero on every entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state != BUSY) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign timeout = (state == BUSY) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // Scheduler state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode: zero-length heads retire in IDLE, engine errors beat done
    always_comb begin
        next_state = state;
        pop_en     = 1'b0;
        pop_ch     = cur_ch;
        done_set   = 1'b0;
        done_ch    = cur_ch;
        err_set    = 1'b0;
        load_cur   = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    if (grant_len == '0) begin
                        pop_en   = 1'b1;
                        pop_ch   = grant_ch;
                        done_set = grant_last;
                        done_ch  = grant_ch;
                    end else begin
                        load_cur   = 1'b1;
                        next_state = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (desc.desc_ready) begin
                    pop_en     = 1'b1;
                    accept     = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (desc.eng_error || timeout) begin
                    err_set    = 1'b1;
                    next_state = IDLE;
                end else if (desc.eng_done) begin
                    done_set   = busy_last;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Active-channel context, round-robin pointer and registered done pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_ch    <= '0;
            busy_last <= 1'b0;
            rr_ptr    <= '0;
            done_irq  <= '0;
        end else begin
            done_irq <= '0;
            if (done_set) begin
                done_irq[done_ch] <= 1'b1;
            end
            if (load_cur) begin
                cur_ch <= grant_ch;
            end
            if (accept) begin
                busy_last <= head_last;
                rr_ptr    <= (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + CH_W'(1);
            end
        end
    end

    assign desc.desc_valid = (state == ISSUE);
    assign desc.desc_src   = desc.desc_valid ? head_src : '0;
    assign desc.desc_dst   = desc.desc_valid ? head_dst : '0;
    assign desc.desc_len   = desc.desc_valid ? head_len : '0;
    assign desc.desc_ch    = desc.desc_valid ? cur_ch   : '0;

    // Pack per-channel occupancy into the flat level bus
    always_comb begin
        ch_level = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_level[i*LVL_W +: LVL_W] = count[i];
        end
    end

    assign err_irq = |(ch_err | ch_ovf);
endmodule
